rx_link_ctrl: RTL and testbench
===============================

Name: rx_link_ctrl

Overview:
Link-level controller for the optical hardware_receiver. It holds the receiver in reset while disabled, releases it, and hunts the receiver's serial output (dout/vout) for a 10-bit sync symbol. It confirms frame alignment over several frames and then delivers aligned 10-bit data words. On repeated sync misses or a hunt timeout it re-sequences the receiver through reset.

Parameters:
SYNC_WORD, 10'b0111111111, symbol marking frame start (word 0 of every frame)
FRAME_LEN, 4, words per frame including the sync word (>=2)
LOCK_COUNT, 3, consecutive correctly placed sync words needed to lock, including the hunt hit
MISS_LIMIT, 2, consecutive missing syncs in LOCKED that force relock
RX_RST_CYCLES, 4, clocks rx_rst is held high in RX_RESET
HUNT_TIMEOUT, 1024, clocks allowed in HUNT before the receiver is reset again

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (block reset while rst==0)
enable  in  1  link enable
din  in  1  serial bit from receiver dout
din_valid  in  1  receiver vout; din is sampled only when high
rx_rst  out  1  active-high reset driven to the receiver
locked  out  1  high in LOCKED only
word_out  out  10  aligned data word, MSB = first received bit
word_valid  out  1  one-clock pulse per delivered data word
frame_start  out  1  one-clock pulse when a sync word is accepted in LOCKED

Behaviour:
- Reset (rst==0, async): state=IDLE, rx_rst=1, locked=0, word_out=0, word_valid=0, frame_start=0, and all counters plus the shift register cleared.
- Shift register: sr <= {sr[8:0], din} on each clock with din_valid=1. cand={sr[8:0],din} is the word ending at the current bit.
- IDLE: rx_rst=1. Moves to RX_RESET when enable=1.
- RX_RESET: rx_rst=1 for exactly RX_RST_CYCLES clocks, then HUNT. sr, bit_cnt, word_idx, hit_cnt, miss_cnt and the timeout counter are cleared. rx_rst=0 in all other states.
- HUNT: on a valid bit with cand==SYNC_WORD, go to CONFIRM with bit_cnt=0, word_idx=1, hit_cnt=1 (if LOCK_COUNT==1, go directly to LOCKED). The timeout counter increments every clock. When it reaches HUNT_TIMEOUT-1 with no hit, go to RX_RESET.
- Word boundary: bit_cnt counts valid bits 0..9. The 10th valid bit (bit_cnt==9) completes a word, cand is evaluated, bit_cnt returns to 0, and word_idx advances modulo FRAME_LEN.
- CONFIRM: data words are discarded. At a word with word_idx==0:
  - cand==SYNC_WORD: hit_cnt++. When hit_cnt reaches LOCK_COUNT, go to LOCKED.
  - otherwise: go to HUNT and clear hit_cnt.
- LOCKED: locked=1.
  - Word with word_idx!=0: word_out<=cand and word_valid=1 on the next clock. Latency is 1 clock after the edge that samples the 10th bit.
  - word_idx==0 and cand==SYNC_WORD: frame_start pulses, miss_cnt=0, and no word_valid.
  - word_idx==0 and cand!=SYNC_WORD: miss_cnt++, no word_valid, and framing is kept. When miss_cnt reaches MISS_LIMIT, go to RX_RESET with locked=0 on the next clock.
- din_valid=0 stalls sr, bit_cnt and word_idx. The HUNT timeout still counts during a stall.
- enable=0 in any state: IDLE on the next clock. locked, word_valid and frame_start drop to 0, word_out holds its last value, rx_rst=1.
- Async reset mid-word: partial word is discarded, no word_valid.
- word_valid and frame_start are never high at the same time. word_out changes only when word_valid is asserted.

Optional Feature:
Macro RX_LINK_STATS_EN.
- Defined: adds output relock_cnt[15:0], which increments, saturating at 16'hFFFF, on every entry to RX_RESET from HUNT or LOCKED (not from IDLE). Also adds output miss_total[15:0], which increments, saturating, on every missed sync in LOCKED. Both counters clear only on rst.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset/enable: rst=0, then rst=1 with enable=0 for 10 clocks → rx_rst=1, locked=0. Raise enable → rx_rst stays high exactly 4 clocks, then 0.
- Lock: after release, send 7 junk bits, then 3 frames of [0111111111, 3 data words] → locked rises after the 3rd sync completes. Words of frame 3 onward appear on word_out with word_valid, one clock after each 10th bit.
- Stall: in LOCKED, hold din_valid=0 for 5 clocks in the middle of a word → no word_valid, and the resumed word is reassembled bit-exact (e.g. 1000000000).
- Miss/relock: in LOCKED, replace 2 consecutive sync words with 0000000000 → no frame_start, locked drops, rx_rst high 4 clocks. With STATS_EN, relock_cnt=1 and miss_total=2. A single miss followed by a good sync keeps the lock.
- Hunt timeout: after release, feed all-zero bits → rx_rst re-asserts after 1024 clocks in HUNT, repeating periodically.
- Confirm failure: send a sync word, then a non-sync word at the next frame boundary → back to HUNT, locked stays 0, and no word_valid throughout.

Source files
------------

// File: rtl/rx_link_ctrl_if.sv
// rx_link_ctrl_if: receiver-facing serial side and aligned-word side of rx_link_ctrl.
// With RX_LINK_STATS_EN defined the link statistics counters are carried too.
interface rx_link_ctrl_if;
  logic       enable;
  logic       din;
  logic       din_valid;
  logic       rx_rst;
  logic       locked;
  logic [9:0] word_out;
  logic       word_valid;
  logic       frame_start;
`ifdef RX_LINK_STATS_EN
  logic [15:0] relock_cnt;
  logic [15:0] miss_total;

  modport master (
    output enable, din, din_valid,
    input  rx_rst, locked, word_out, word_valid, frame_start, relock_cnt, miss_total
  );
  modport slave (
    input  enable, din, din_valid,
    output rx_rst, locked, word_out, word_valid, frame_start, relock_cnt, miss_total
  );
`else
  modport master (
    output enable, din, din_valid,
    input  rx_rst, locked, word_out, word_valid, frame_start
  );
  modport slave (
    input  enable, din, din_valid,
    output rx_rst, locked, word_out, word_valid, frame_start
  );
`endif
endinterface

// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl: resets the optical receiver, hunts for the sync symbol, confirms
// frame alignment and delivers aligned 10-bit words. Option macro: RX_LINK_STATS_EN.
module rx_link_ctrl #(
  parameter logic [9:0] SYNC_WORD     = 10'b0111111111,
  parameter int         FRAME_LEN     = 4,
  parameter int         LOCK_COUNT    = 3,
  parameter int         MISS_LIMIT    = 2,
  parameter int         RX_RST_CYCLES = 4,
  parameter int         HUNT_TIMEOUT  = 1024
) (
  input logic           clk,
  input logic           rst,
  rx_link_ctrl_if.slave lnk
);

  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam int RST_W  = (RX_RST_CYCLES > 1) ? $clog2(RX_RST_CYCLES) : 1;
  localparam int TMO_W  = $clog2(HUNT_TIMEOUT);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);
  localparam logic [HIT_W-1:0]  HIT_ONE   = HIT_W'(1);
  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
  localparam logic [RST_W-1:0]  RST_ONE   = RST_W'(1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RX_RST_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(HUNT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_RESET = 3'd1,
    HUNT     = 3'd2,
    CONFIRM  = 3'd3,
    LOCKED   = 3'd4
  } state_t;

  state_t            state_r;
  logic [8:0]        sr_r;
  logic [3:0]        bit_cnt_r;
  logic [IDX_W-1:0]  word_idx_r;
  logic [HIT_W-1:0]  hit_cnt_r;
  logic [MISS_W-1:0] miss_cnt_r;
  logic [RST_W-1:0]  rst_cnt_r;
  logic [TMO_W-1:0]  tmo_r;
  logic              rx_rst_r;
  logic              locked_r;
  logic [9:0]        word_out_r;
  logic              word_valid_r;
  logic              frame_start_r;

  logic [9:0]       cand_s;
  logic             sync_s;
  logic             word_done_s;
  logic             idx0_s;
  logic [IDX_W-1:0] next_idx_s;
  logic             miss_ev_s;
  logic             tmo_ev_s;

  // Only nine history bits are kept: the tenth bit of a candidate is always the live din.
  assign cand_s      = {sr_r, lnk.din};
  assign sync_s      = (cand_s == SYNC_WORD);
  assign word_done_s = lnk.din_valid && (bit_cnt_r == 4'd9);
  assign idx0_s      = (word_idx_r == '0);
  assign next_idx_s  = (word_idx_r == IDX_LAST) ? '0 : (word_idx_r + IDX_ONE);
  assign miss_ev_s   = lnk.enable && (state_r == LOCKED) && word_done_s && idx0_s && !sync_s;
  assign tmo_ev_s    = lnk.enable && (state_r == HUNT) && !(lnk.din_valid && sync_s)
                       && (tmo_r == TMO_LAST);

  assign lnk.rx_rst      = rx_rst_r;
  assign lnk.locked      = locked_r;
  assign lnk.word_out    = word_out_r;
  assign lnk.word_valid  = word_valid_r;
  assign lnk.frame_start = frame_start_r;

  // Link FSM with framing counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      sr_r          <= 9'd0;
      bit_cnt_r     <= 4'd0;
      word_idx_r    <= '0;
      hit_cnt_r     <= '0;
      miss_cnt_r    <= '0;
      rst_cnt_r     <= '0;
      tmo_r         <= '0;
      rx_rst_r      <= 1'b1;
      locked_r      <= 1'b0;
      word_out_r    <= 10'd0;
      word_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      word_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
      if (!lnk.enable) begin
        state_r    <= IDLE;
        rx_rst_r   <= 1'b1;
        locked_r   <= 1'b0;
        sr_r       <= 9'd0;
        bit_cnt_r  <= 4'd0;
        word_idx_r <= '0;
        hit_cnt_r  <= '0;
        miss_cnt_r <= '0;
        rst_cnt_r  <= '0;
        tmo_r      <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r   <= RX_RESET;
            rx_rst_r  <= 1'b1;
            rst_cnt_r <= '0;
          end
          RX_RESET: begin
            sr_r       <= 9'd0;
            bit_cnt_r  <= 4'd0;
            word_idx_r <= '0;
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
            tmo_r      <= '0;
            if (rst_cnt_r == RST_LAST) begin
              state_r  <= HUNT;
              rx_rst_r <= 1'b0;
            end else begin
              rst_cnt_r <= rst_cnt_r + RST_ONE;
            end
          end
          HUNT: begin
            tmo_r <= tmo_r + TMO_ONE;
            if (lnk.din_valid) begin
              sr_r <= cand_s[8:0];
            end
            if (lnk.din_valid && sync_s) begin
              bit_cnt_r  <= 4'd0;
              word_idx_r <= IDX_ONE;
              hit_cnt_r  <= HIT_ONE;
              tmo_r      <= '0;
              if (LOCK_COUNT == 1) begin
                state_r    <= LOCKED;
                locked_r   <= 1'b1;
                miss_cnt_r <= '0;
              end else begin
                state_r <= CONFIRM;
              end
            end else if (tmo_ev_s) begin
              state_r   <= RX_RESET;
              rx_rst_r  <= 1'b1;
              rst_cnt_r <= '0;
            end
          end
          CONFIRM: begin
            if (lnk.din_valid) begin
              sr_r <= cand_s[8:0];
              if (word_done_s) begin
                bit_cnt_r  <= 4'd0;
                word_idx_r <= next_idx_s;
                if (idx0_s && sync_s) begin
                  if (hit_cnt_r == HIT_LAST) begin
                    state_r    <= LOCKED;
                    locked_r   <= 1'b1;
                    miss_cnt_r <= '0;
                  end else begin
                    hit_cnt_r <= hit_cnt_r + HIT_ONE;
                  end
                end else if (idx0_s) begin
                  state_r   <= HUNT;
                  hit_cnt_r <= '0;
                  tmo_r     <= '0;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          LOCKED: begin
            if (lnk.din_valid) begin
              sr_r <= cand_s[8:0];
              if (word_done_s) begin
                bit_cnt_r  <= 4'd0;
                word_idx_r <= next_idx_s;
                if (!idx0_s) begin
                  word_out_r   <= cand_s;
                  word_valid_r <= 1'b1;
                end else if (sync_s) begin
                  frame_start_r <= 1'b1;
                  miss_cnt_r    <= '0;
                end else if (miss_cnt_r == MISS_LAST) begin
                  state_r   <= RX_RESET;
                  locked_r  <= 1'b0;
                  rx_rst_r  <= 1'b1;
                  rst_cnt_r <= '0;
                end else begin
                  miss_cnt_r <= miss_cnt_r + MISS_ONE;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          default: begin
            state_r  <= IDLE;
            rx_rst_r <= 1'b1;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RX_LINK_STATS_EN
  logic [15:0] relock_cnt_r;
  logic [15:0] miss_total_r;
  logic        relock_ev_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  assign relock_ev_s    = tmo_ev_s || (miss_ev_s && (miss_cnt_r == MISS_LAST));
  assign lnk.relock_cnt = relock_cnt_r;
  assign lnk.miss_total = miss_total_r;

  // Statistics survive enable drops and clear only on block reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      relock_cnt_r <= 16'd0;
      miss_total_r <= 16'd0;
    end else begin
      if (relock_ev_s) begin
        relock_cnt_r <= sat_inc(relock_cnt_r);
      end
      if (miss_ev_s) begin
        miss_total_r <= sat_inc(miss_total_r);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Self-checking bench for rx_link_ctrl: table-driven lock sequence, hand-written
// corner sequences and a word scoreboard fed by the stimulus.
module tb_rx_link_ctrl;

  logic clk;
  logic rst;
  rx_link_ctrl_if lnk ();

  rx_link_ctrl dut (
    .clk (clk),
    .rst (rst),
    .lnk (lnk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] w;
    logic       v;
    logic       fs;
    logic       lk;
  } vec_t;

  vec_t       tbl [16];
  logic [9:0] sb [$];
  logic [9:0] mexp;
  logic [9:0] last_word;
  int         total;
  int         bad;
  int         n;
  int         exp_relock;
  int         exp_miss;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Sends one 10-bit word MSB first; optionally stalls 5 clocks before bit stall_at.
  task automatic send_word(input logic [9:0] w, input logic ev, input int stall_at);
    for (int i = 0; i < 10; i++) begin
      if (i == stall_at) begin
        lnk.din_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_no_wv", 32'(lnk.word_valid), 32'd0);
        end
      end
      if (i == 9 && ev) begin
        sb.push_back(w);
        last_word = w;
      end
      lnk.din       = w[9-i];
      lnk.din_valid = 1'b1;
      tick();
    end
  endtask

  task automatic run_table(input string tag);
    for (int k = 0; k < 16; k++) begin
      send_word(tbl[k].w, tbl[k].v, 99);
      chk({tag, "_locked"}, 32'(lnk.locked), 32'(tbl[k].lk));
      chk({tag, "_wv"}, 32'(lnk.word_valid), 32'(tbl[k].v));
      chk({tag, "_fs"}, 32'(lnk.frame_start), 32'(tbl[k].fs));
    end
  endtask

  // Counts observations with rx_rst high, starting from 'start' already seen.
  task automatic count_high(input int start, input string nm);
    n = start;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (lnk.rx_rst) n++;
      else break;
    end
    chk(nm, 32'(n), 32'd4);
  endtask

  // Word scoreboard: every word_valid must match the oldest expected word.
  always begin
    @(posedge clk);
    #1;
    if (lnk.word_valid && lnk.frame_start) begin
      total++;
      bad++;
      $display("FAIL wv_fs_overlap: got both high want at most one");
    end
    if (lnk.word_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got word %0h want no word_valid", lnk.word_out);
      end else begin
        mexp = sb.pop_front();
        chk("sb_word", 32'(lnk.word_out), 32'(mexp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{10'h1FF, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{10'h155, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{10'h2AA, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{10'h3FF, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{10'h1FF, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{10'h001, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{10'h200, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{10'h0F0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{10'h1FF, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{10'h123, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{10'h3C5, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{10'h000, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{10'h1FF, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{10'h200, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{10'h1FF, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{10'h3FE, 1'b1, 1'b0, 1'b1};
    total = 0;
    bad = 0;
    last_word = 10'h000;
    exp_relock = 0;
    exp_miss = 0;

    rst = 1'b0;
    lnk.enable = 1'b0;
    lnk.din = 1'b0;
    lnk.din_valid = 1'b0;
    repeat (3) tick();
    chk("rst_rx_rst", 32'(lnk.rx_rst), 32'd1);
    chk("rst_locked", 32'(lnk.locked), 32'd0);
    chk("rst_word_out", 32'(lnk.word_out), 32'd0);
    chk("rst_wv", 32'(lnk.word_valid), 32'd0);
    chk("rst_fs", 32'(lnk.frame_start), 32'd0);
    rst = 1'b1;
    repeat (10) tick();
    chk("idle_rx_rst", 32'(lnk.rx_rst), 32'd1);
    chk("idle_locked", 32'(lnk.locked), 32'd0);

    lnk.enable = 1'b1;
    count_high(0, "release_len");

    // Junk bits ahead of the first sync, then three frames to lock and one locked frame.
    for (int i = 0; i < 7; i++) begin
      lnk.din = i[0] ? 1'b0 : 1'b1;
      lnk.din_valid = 1'b1;
      tick();
    end
    run_table("lock");

    // Stall in the middle of a data word.
    send_word(10'h1FF, 1'b0, 99);
    chk("stall_frame_fs", 32'(lnk.frame_start), 32'd1);
    send_word(10'h200, 1'b1, 4);
    chk("stall_word_wv", 32'(lnk.word_valid), 32'd1);
    chk("stall_locked", 32'(lnk.locked), 32'd1);
    send_word(10'h2AB, 1'b1, 99);
    send_word(10'h0C3, 1'b1, 99);

    // Single miss followed by a good sync keeps the lock.
    send_word(10'h000, 1'b0, 99);
    exp_miss++;
    chk("miss1_fs", 32'(lnk.frame_start), 32'd0);
    chk("miss1_locked", 32'(lnk.locked), 32'd1);
    send_word(10'h111, 1'b1, 99);
    send_word(10'h222, 1'b1, 99);
    send_word(10'h333, 1'b1, 99);
    send_word(10'h1FF, 1'b0, 99);
    chk("resync_fs", 32'(lnk.frame_start), 32'd1);
    chk("resync_locked", 32'(lnk.locked), 32'd1);
    send_word(10'h0AA, 1'b1, 99);
    send_word(10'h355, 1'b1, 99);
    send_word(10'h3FF, 1'b1, 99);

    // Two consecutive misses force a relock.
    send_word(10'h000, 1'b0, 99);
    exp_miss++;
    chk("miss2a_locked", 32'(lnk.locked), 32'd1);
    send_word(10'h00F, 1'b1, 99);
    send_word(10'h0F0, 1'b1, 99);
    send_word(10'h300, 1'b1, 99);
    send_word(10'h000, 1'b0, 99);
    exp_miss++;
    exp_relock++;
    chk("miss2b_fs", 32'(lnk.frame_start), 32'd0);
    chk("miss2b_locked", 32'(lnk.locked), 32'd0);
    chk("miss2b_rx_rst", 32'(lnk.rx_rst), 32'd1);
    lnk.din = 1'b0;
    lnk.din_valid = 1'b1;
    count_high(1, "relock_rst_len");
`ifdef RX_LINK_STATS_EN
    chk("stats_relock1", 32'(lnk.relock_cnt), 32'(exp_relock));
    chk("stats_miss", 32'(lnk.miss_total), 32'(exp_miss));
`endif

    // Hunt timeout on all-zero input, twice in a row.
    for (int r = 0; r < 2; r++) begin
      n = 0;
      for (int i = 0; i < 3000; i++) begin
        tick();
        n++;
        if (lnk.rx_rst) break;
      end
      chk("hunt_timeout_len", 32'(n), 32'd1024);
      exp_relock++;
      count_high(1, "timeout_rst_len");
    end
`ifdef RX_LINK_STATS_EN
    chk("stats_relock3", 32'(lnk.relock_cnt), 32'(exp_relock));
`endif

    // Confirm failure: sync, data, then a near-sync word at the next frame boundary.
    send_word(10'h006, 1'b0, 7);
    send_word(10'h1FF, 1'b0, 99);
    chk("cf_locked_a", 32'(lnk.locked), 32'd0);
    send_word(10'h0FF, 1'b0, 99);
    send_word(10'h3FF, 1'b0, 99);
    send_word(10'h155, 1'b0, 99);
    send_word(10'h17F, 1'b0, 99);
    chk("cf_locked_b", 32'(lnk.locked), 32'd0);
    chk("cf_wv", 32'(lnk.word_valid), 32'd0);
    run_table("relock");

    // Enable drop while locked.
    lnk.din_valid = 1'b0;
    lnk.enable = 1'b0;
    tick();
    chk("dis_locked", 32'(lnk.locked), 32'd0);
    chk("dis_rx_rst", 32'(lnk.rx_rst), 32'd1);
    chk("dis_wv", 32'(lnk.word_valid), 32'd0);
    chk("dis_word_hold", 32'(lnk.word_out), 32'(last_word));
    repeat (3) tick();
    chk("dis_rx_rst_hold", 32'(lnk.rx_rst), 32'd1);
    lnk.enable = 1'b1;
    count_high(0, "reenable_rst_len");
`ifdef RX_LINK_STATS_EN
    chk("stats_relock_idle", 32'(lnk.relock_cnt), 32'(exp_relock));
`endif
    run_table("third");

    // Asynchronous reset in the middle of a data word.
    for (int i = 0; i < 5; i++) begin
      lnk.din = 1'b1;
      lnk.din_valid = 1'b1;
      tick();
    end
    #3;
    rst = 1'b0;
    #1;
    chk("arst_locked", 32'(lnk.locked), 32'd0);
    chk("arst_rx_rst", 32'(lnk.rx_rst), 32'd1);
    chk("arst_word_out", 32'(lnk.word_out), 32'd0);
`ifdef RX_LINK_STATS_EN
    chk("arst_relock", 32'(lnk.relock_cnt), 32'd0);
    chk("arst_miss", 32'(lnk.miss_total), 32'd0);
`endif
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lnk.din = 1'b0;
      lnk.din_valid = 1'b1;
      tick();
    end
    chk("arst_after_locked", 32'(lnk.locked), 32'd0);
    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
